// File: rtl/peg_l2_rs_rmii_rx_pkt_if.sv
// Packet word stream from the RMII receive block to the MAC RX.
// The master drives the word and its framing flags; the slave returns pkt_ready.
interface peg_l2_rs_rmii_rx_pkt_if #(
  parameter int PKT_DATA_W = 8
) ();
  localparam int BYTES_W = $clog2(PKT_DATA_W/8) + 1;

  logic                  pkt_valid;
  logic                  pkt_sop;
  logic                  pkt_eop;
  logic [PKT_DATA_W-1:0] pkt_data;
  logic [BYTES_W-1:0]    pkt_bytes;
  logic                  pkt_error;
  logic                  pkt_ready;

  modport master (
    output pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_bytes, pkt_error,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_bytes, pkt_error,
    output pkt_ready
  );
endinterface

// File: rtl/peg_l2_rs_rmii_rx_pkt.sv
// RMII receive reconciliation: samples dibits at 10/100 Mbps, strips preamble/SFD,
// packs frame bytes into words with SOP/EOP/error and buffers them in a show-ahead FIFO.
module peg_l2_rs_rmii_rx_pkt #(
  parameter int PKT_DATA_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNTR_W     = 16
) (
  input  logic                  rmii_ref_clk,
  input  logic                  rst,
  input  logic                  config_rs_mii_speed_100_n_10,
  input  logic                  rmii_crs_dv,
  input  logic [1:0]            rmii_rxd,
  input  logic                  rmii_rx_er,
  peg_l2_rs_rmii_rx_pkt_if.master pkt,
  output logic [CNTR_W-1:0]     stat_frm_cnt,
  output logic [CNTR_W-1:0]     stat_err_cnt,
  output logic [CNTR_W-1:0]     stat_drop_cnt
);

  localparam int NB = PKT_DATA_W / 8;
  localparam int BW = $clog2(NB) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_e;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [BW-1:0]         bytes;
    logic [PKT_DATA_W-1:0] data;
  } ent_t;

  function automatic logic [CNTR_W-1:0] sat_add(input logic [CNTR_W-1:0] c,
                                                input logic [1:0]        inc);
    logic [CNTR_W:0] s;
    s = {1'b0, c} + (CNTR_W+1)'(inc);
    return s[CNTR_W] ? '1 : s[CNTR_W-1:0];
  endfunction

  // Sample strobe
  logic       crs_prev_q;
  logic [3:0] dec_q, dec_d, dec_cur;
  logic       stb;

  always_comb begin
    dec_cur = (rmii_crs_dv && !crs_prev_q) ? 4'd0 : dec_q;
    dec_d   = (dec_cur == 4'd9) ? 4'd0 : dec_cur + 4'd1;
    stb     = config_rs_mii_speed_100_n_10 ? 1'b1 : (dec_cur == 4'd9);
  end

  always_ff @(posedge rmii_ref_clk) begin
    if (rst) begin
      crs_prev_q <= 1'b0;
      dec_q      <= '0;
    end else begin
      crs_prev_q <= rmii_crs_dv;
      dec_q      <= dec_d;
    end
  end

  // FIFO state and push arbitration
  ent_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  ent_t          head, wr_ent, hold_ent;
  logic          empty, full, pop, space, wr_en, ovf;

  logic          push_q;
  ent_t          push_ent_q;
  logic          hold_vld_q;

  always_comb begin
    hold_ent       = '0;
    hold_ent.eop   = 1'b1;
    hold_ent.err   = 1'b1;
    head   = mem_q[rd_ptr_q];
    empty  = (count_q == '0);
    full   = (count_q == (AW+1)'(FIFO_DEPTH));
    pop    = !empty && pkt.pkt_ready;
    space  = !full || pop;
    wr_en  = (push_q || hold_vld_q) && space;
    wr_ent = hold_vld_q ? hold_ent : push_ent_q;
    ovf    = push_q && !space;
  end

  always_ff @(posedge rmii_ref_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_ent;
  end

  always_ff @(posedge rmii_ref_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Receive FSM and byte/word assembly
  state_e                state_q;
  logic [7:0]            sr_q;
  logic [1:0]            dib_q;
  logic [PKT_DATA_W-1:0] word_q;
  logic [BW-1:0]         bcnt_q;
  logic                  first_q, err_q;
  logic                  drop_pls_q, zb_pls_q;
  logic [7:0]            nbyte;

  assign nbyte = {rmii_rxd, sr_q[7:2]};

  always_ff @(posedge rmii_ref_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dib_q      <= '0;
      bcnt_q     <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      push_q     <= 1'b0;
      hold_vld_q <= 1'b0;
      drop_pls_q <= 1'b0;
      zb_pls_q   <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      drop_pls_q <= 1'b0;
      zb_pls_q   <= 1'b0;
      if (hold_vld_q && space) hold_vld_q <= 1'b0;

      if (stb) begin
        unique case (state_q)
          S_IDLE: begin
            if (rmii_crs_dv && rmii_rxd == 2'b01) state_q <= S_PRE;
          end
          S_PRE: begin
            if (!rmii_crs_dv) begin
              state_q <= S_IDLE;
            end else if (rmii_rxd == 2'b11) begin
              // A truncated frame's eop still waiting means this frame cannot be accepted.
              if (hold_vld_q) begin
                state_q    <= S_DROP;
                drop_pls_q <= 1'b1;
              end else begin
                state_q <= S_DATA;
                dib_q   <= '0;
                bcnt_q  <= '0;
                first_q <= 1'b1;
                err_q   <= 1'b0;
              end
            end else if (rmii_rxd != 2'b01) begin
              state_q <= S_IDLE;
            end
          end
          S_DATA: begin
            if (!rmii_crs_dv) begin
              state_q <= S_IDLE;
              if (bcnt_q != '0) begin
                push_q           <= 1'b1;
                push_ent_q.sop   <= first_q;
                push_ent_q.eop   <= 1'b1;
                push_ent_q.err   <= err_q || (dib_q != 2'd0);
                push_ent_q.bytes <= bcnt_q;
                push_ent_q.data  <= word_q;
              end else begin
                zb_pls_q <= 1'b1;
              end
            end else begin
              if (rmii_rx_er) err_q <= 1'b1;
              sr_q  <= nbyte;
              dib_q <= dib_q + 2'd1;
              if (dib_q == 2'd3) begin
                // A full word is held back until the next byte proves it is not the last.
                if (bcnt_q == BW'(NB)) begin
                  push_q           <= 1'b1;
                  push_ent_q.sop   <= first_q;
                  push_ent_q.eop   <= 1'b0;
                  push_ent_q.err   <= 1'b0;
                  push_ent_q.bytes <= BW'(NB);
                  push_ent_q.data  <= word_q;
                  first_q          <= 1'b0;
                  word_q           <= PKT_DATA_W'(nbyte);
                  bcnt_q           <= BW'(1);
                end else begin
                  for (int i = 0; i < NB; i++) begin
                    if (bcnt_q == BW'(i)) word_q[i*8 +: 8] <= nbyte;
                  end
                  bcnt_q <= bcnt_q + BW'(1);
                end
              end
            end
          end
          S_DROP: begin
            if (!rmii_crs_dv) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end

      if (ovf) begin
        hold_vld_q <= 1'b1;
        drop_pls_q <= 1'b1;
        if (!push_ent_q.eop) begin
          push_q  <= 1'b0;
          state_q <= (stb && !rmii_crs_dv) ? S_IDLE : S_DROP;
        end
      end
    end
  end

  // Statistics, counted as eop words leave the FIFO
  logic       frm_inc;
  logic [1:0] err_inc;

  always_comb begin
    frm_inc = pop && head.eop && !head.err;
    err_inc = {1'b0, pop && head.eop && head.err} + {1'b0, zb_pls_q};
  end

  always_ff @(posedge rmii_ref_clk) begin
    if (rst) begin
      stat_frm_cnt  <= '0;
      stat_err_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else begin
      stat_frm_cnt  <= sat_add(stat_frm_cnt, {1'b0, frm_inc});
      stat_err_cnt  <= sat_add(stat_err_cnt, err_inc);
      stat_drop_cnt <= sat_add(stat_drop_cnt, {1'b0, drop_pls_q});
    end
  end

  assign pkt.pkt_valid = !empty;
  assign pkt.pkt_sop   = !empty && head.sop;
  assign pkt.pkt_eop   = !empty && head.eop;
  assign pkt.pkt_error = !empty && head.err;
  assign pkt.pkt_bytes = empty ? '0 : head.bytes;
  assign pkt.pkt_data  = empty ? '0 : head.data;

endmodule

// File: doc/peg_l2_rs_rmii_rx_pkt.md
Name: peg_l2_rs_rmii_rx_pkt

Overview:
Next-generation RMII receive reconciliation block, running on the RMII reference clock.
- Samples RMII dibits at 100 Mbps or 10 Mbps.
- Strips preamble/SFD and assembles frame bytes into PKT_DATA_W-wide words with real SOP/EOP, last-word byte count and error marking.
- Buffers words in a FIFO so the downstream MAC RX can apply backpressure via pkt_ready.

Parameters:
PKT_DATA_W, 8, output word width; multiple of 8 (8/16/32).
FIFO_DEPTH, 16, word FIFO depth; power of 2, min 4.
CNTR_W, 16, width of statistics counters.

Ports:
rmii_ref_clk  in  1  50 MHz RMII reference clock; the only clock.
rst  in  1  synchronous reset, active-high.
config_rs_mii_speed_100_n_10  in  1  1=100 Mbps, 0=10 Mbps; change only while idle.
rmii_crs_dv  in  1  carrier sense / data valid from PHY.
rmii_rxd  in  2  receive dibit, LSB-first within byte.
rmii_rx_er  in  1  PHY receive error.
pkt_valid  out  1  FIFO head word valid.
pkt_sop  out  1  head word is first word of frame.
pkt_eop  out  1  head word is last word of frame.
pkt_data  out  PKT_DATA_W  frame data; first byte in bits [7:0].
pkt_bytes  out  $clog2(PKT_DATA_W/8)+1  valid bytes in word; full count unless eop.
pkt_ready  in  1  downstream accepts head word when high with pkt_valid.
pkt_error  out  1  frame errored; meaningful with pkt_eop.
stat_frm_cnt  out  CNTR_W  good frames delivered.
stat_err_cnt  out  CNTR_W  frames delivered with pkt_error.
stat_drop_cnt  out  CNTR_W  frames dropped due to FIFO overflow.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE, counters 0. Reset mid-frame discards the frame, with no eop emitted.
- Sample strobe:
  - 100 Mbps: every cycle.
  - 10 Mbps: decimation counter 0..9 restarts at 0 on rising crs_dv; strobe at count 9.
  - All FSM actions occur only on strobe.
- FSM:
  - IDLE: crs_dv=1 and rxd=2'b01 -> PREAMBLE.
  - PREAMBLE: rxd=01 stay; rxd=11 -> DATA (SFD); other value or crs_dv=0 -> IDLE, nothing emitted.
  - DATA: shift dibits into byte, LSB first; every 4th dibit appends a byte to the word; a full word is pushed with sop set if it is the frame's first word. crs_dv=0 at strobe -> end of frame, go IDLE.
  - DROP: discard until crs_dv=0, then IDLE.
- End of frame:
  - Push the partial or full word with eop=1 and pkt_bytes = bytes held.
  - A pending full word not yet pushed becomes the eop word.
  - Zero-byte frame (SFD then crs_dv=0): nothing emitted, counted in stat_err_cnt.
- Error:
  - Sticky err flag per frame; set by rx_er=1 at any strobe in DATA, or by a non-zero dibit count at end (dribble bits).
  - Dribble bits are discarded, not emitted.
  - err is loaded into the eop word.
- FIFO:
  - Show-ahead: pkt_valid = !empty.
  - Pop on pkt_valid & pkt_ready.
  - Push-to-pkt_valid latency: 1 cycle after the push cycle.
  - Simultaneous push and pop when full is allowed.
- Overflow:
  - A push when full and not popping loses the word; FSM -> DROP.
  - A pending eop word (sop=0, eop=1, bytes=0, error=1) is held in a single holding register and pushed as soon as space exists.
  - New frames arriving while the holding register is occupied are dropped whole.
  - stat_drop_cnt increments once per dropped frame; such truncated frames also increment stat_err_cnt on delivery.
- Counters:
  - Update when an eop word is popped: error=0 -> stat_frm_cnt, error=1 -> stat_err_cnt.
  - Saturate at all-ones; no wrap.
- Back-to-back frames:
  - crs_dv low for a single strobe is sufficient to separate frames.
  - A new preamble may begin on the next strobe.

Test Plan:
- 100 Mbps, PKT_DATA_W=8, preamble 7x55 + D5 + 64 bytes 00..3F, pkt_ready=1 -> 64 words; word 0 sop=1, data 00; word 63 eop=1, data 3F, error=0; stat_frm_cnt=1.
- PKT_DATA_W=32, 61-byte frame -> 16 words; first data 0x03020100; last word eop=1, pkt_bytes=1.
- 10 Mbps, each dibit held 10 cycles, 8-byte frame -> 8 bytes correct; no duplicate samples; stat_frm_cnt=1.
- rx_er pulsed during byte 5 of a 20-byte frame -> 20 words; eop word error=1; stat_err_cnt=1. Separate case: frame ending with 2 extra dibits -> eop error=1, dribble bits discarded.
- FIFO_DEPTH=4, pkt_ready=0 during a 10-byte frame, then ready=1 -> 4 data words, then eop word with error=1 and bytes=0; stat_drop_cnt=1; a following 6-byte frame delivered cleanly.
- Assert rst mid-frame, then send a clean frame -> no eop for the aborted frame; clean frame intact; counters 0 until the clean frame completes.
